// File: rtl/cmd_frame_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cmd_frame_loader_if : byte stream in, parallel command fields out   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface cmd_frame_loader_if;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [47:0] freq;
  logic [47:0] freq_step;
  logic [31:0] freq_rate;
  logic [63:0] time_start;
  logic [15:0] n_impulse;
  logic [1:0]  type_impulse;
  logic [31:0] interval_ti;
  logic [31:0] interval_tp;
  logic [31:0] tblank1;
  logic [31:0] tblank2;
  logic        spi_wr;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  modport slave (
    input  din, din_valid,
    output din_ready, freq, freq_step, freq_rate, time_start, n_impulse,
           type_impulse, interval_ti, interval_tp, tblank1, tblank2,
           spi_wr, frame_ok, frame_err, err_code, busy
  );

  modport master (
    output din, din_valid,
    input  din_ready, freq, freq_step, freq_rate, time_start, n_impulse,
           type_impulse, interval_ti, interval_tp, tblank1, tblank2,
           spi_wr, frame_ok, frame_err, err_code, busy
  );
endinterface
`default_nettype wire

// File: rtl/cmd_frame_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cmd_frame_loader : parses a 45-byte command frame, commits on good  |
// | checksum and strobes SPI_WR.  Rev 1.0                               |
// +--------------------------------------------------------------------+
module cmd_frame_loader #(
  parameter logic [7:0]  HEADER   = 8'hA5,
  parameter int unsigned TIMEOUT  = 4800,
  parameter int unsigned WR_PULSE = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  cmd_frame_loader_if.slave bus
);
  localparam int unsigned          c_PAY_BYTES = 43;
  localparam int unsigned          c_TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [c_TMO_W-1:0]   c_TMO_LAST  = c_TMO_W'(TIMEOUT - 1);
  localparam logic [3:0]           c_WR_LAST   = 4'(WR_PULSE - 1);
  localparam logic [5:0]           c_IDX_LAST  = 6'(c_PAY_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CSUM    = 2'd2,
    S_WRITE   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [5:0]               idx_q, idx_d;
  logic [7:0]               sum_q, sum_d;
  logic [c_PAY_BYTES*8-1:0] shadow_q, shadow_d;
  logic [337:0]             fields_q, fields_d;
  logic [c_TMO_W-1:0]       tmo_q, tmo_d;
  logic [3:0]               wr_q, wr_d;
  logic                     err_q, err_d;
  logic [1:0]               code_q, code_d;
  logic                     w_take;

  assign w_take = bus.din_valid & bus.din_ready;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      sum_q    <= '0;
      shadow_q <= '0;
      fields_q <= '0;
      tmo_q    <= '0;
      wr_q     <= '0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      shadow_q <= shadow_d;
      fields_q <= fields_d;
      tmo_q    <= tmo_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    shadow_d = shadow_q;
    fields_d = fields_q;
    tmo_d    = tmo_q;
    wr_d     = wr_q;
    err_d    = 1'b0;
    code_d   = code_q;
    unique case (state_q)
      S_IDLE: begin
        if (w_take && (bus.din == HEADER)) begin
          state_d = S_PAYLOAD;
          idx_d   = '0;
          sum_d   = '0;
          tmo_d   = '0;
        end
      end
      S_PAYLOAD: begin
        if (w_take) begin
          shadow_d = {shadow_q[c_PAY_BYTES*8-9:0], bus.din};
          sum_d    = sum_q + bus.din;
          idx_d    = idx_q + 6'd1;
          tmo_d    = '0;
          if (idx_q == c_IDX_LAST) state_d = S_CSUM;
        end else if (tmo_q == c_TMO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          code_d  = 2'b10;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CSUM: begin
        if (w_take) begin
          if (bus.din == sum_q) begin
            // The TYPE byte keeps only bits [1:0]; its upper six bits are dropped here.
            fields_d = {shadow_q[343:136], shadow_q[129:0]};
            wr_d     = '0;
            state_d  = S_WRITE;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'b01;
            state_d = S_IDLE;
          end
        end else if (tmo_q == c_TMO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          code_d  = 2'b10;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (wr_q == c_WR_LAST) state_d = S_IDLE;
        else                   wr_d    = wr_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.din_ready    = (state_q != S_WRITE);
  assign bus.spi_wr       = (state_q == S_WRITE);
  assign bus.frame_ok     = (state_q == S_WRITE) && (wr_q == c_WR_LAST);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.frame_err    = err_q;
  assign bus.err_code     = code_q;

  assign bus.freq         = fields_q[337:290];
  assign bus.freq_step    = fields_q[289:242];
  assign bus.freq_rate    = fields_q[241:210];
  assign bus.time_start   = fields_q[209:146];
  assign bus.n_impulse    = fields_q[145:130];
  assign bus.type_impulse = fields_q[129:128];
  assign bus.interval_ti  = fields_q[127:96];
  assign bus.interval_tp  = fields_q[95:64];
  assign bus.tblank1      = fields_q[63:32];
  assign bus.tblank2      = fields_q[31:0];
endmodule
`default_nettype wire
